rv_mem_arb: RTL and testbench
=============================

RV_MEM_ARB -- requirements
Module: rv_mem_arb

Interface
REQ-001 SHALL have parameter DPWIDTH, default 32, the width of address and data buses.
REQ-002 SHALL have parameter TIMEOUT, default 16, the maximum number of mem_req cycles without mem_ack (legal range 2..255).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, the rising-edge clock.
REQ-005 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port if_req, input, 1, the instruction fetch request, held high until if_done.
REQ-007 SHALL have port if_addr, input, DPWIDTH, the fetch address.
REQ-008 SHALL have port if_done, output, 1, a one-cycle fetch completion pulse.
REQ-009 SHALL have port d_req, input, 1, the data access request, held high until d_done.
REQ-010 SHALL have ports d_we (input, 1, write=1), d_addr (input, DPWIDTH) and d_wdata (input, DPWIDTH), carrying the data access attributes.
REQ-011 SHALL have port d_done, output, 1, a one-cycle data completion pulse.
REQ-012 SHALL have port rdata, output, DPWIDTH, the read data, valid only while if_done or d_done is high.
REQ-013 SHALL have port err, output, 1, a timeout flag, high only together with if_done or d_done.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, DPWIDTH) and mem_wdata (output, DPWIDTH), forming the unified memory request.
REQ-016 SHALL have ports mem_ack (input, 1) and mem_rdata (input, DPWIDTH), forming the memory response; mem_rdata is valid when mem_ack is high.

Function
REQ-017 SHALL implement an FSM with states IDLE, DACC, IACC and RESP; every output SHALL be registered.
REQ-018 In IDLE, d_req=1 SHALL move the FSM to DACC and latch d_we, d_addr and d_wdata; otherwise if_req=1 SHALL move it to IACC and latch if_addr with we=0. Data has priority when both requests are high.
REQ-019 In DACC or IACC, mem_req SHALL be 1 and mem_we, mem_addr and mem_wdata SHALL hold the latched values, stable until the state is left.
REQ-020 In DACC or IACC, mem_ack=1 SHALL latch mem_rdata into rdata, set err=0 and move the FSM to RESP.
REQ-021 SHALL count cycles spent in DACC or IACC; if the count reaches TIMEOUT with mem_ack still low, the FSM SHALL move to RESP with err=1 and rdata=0.
REQ-022 mem_ack arriving in the same cycle as the timeout SHALL win (err=0).
REQ-023 In RESP, exactly one of if_done/d_done SHALL be high, selected by the latched source, and the next state SHALL be IDLE.
REQ-024 In RESP, requests SHALL be ignored; requesters drop their request in the cycle after done.
REQ-025 For a write, rdata SHALL still capture mem_rdata; its value is unspecified to the requester.
REQ-026 mem_ack in IDLE or RESP SHALL be ignored.
REQ-027 Deasserting a request in DACC or IACC SHALL NOT abort the transaction; it completes normally.
REQ-028 Latency SHALL be: request sampled at edge k, mem_req high from cycle k+1; mem_ack sampled at edge m, done high in cycle m+1. The minimum request-to-done time is 2 cycles, and the minimum spacing between accepts is 3 cycles.
REQ-029 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide, SHALL clear on entry to DACC/IACC, and SHALL saturate rather than wrap.

Reset
REQ-030 On rst=1 at a clock edge, state SHALL become IDLE; mem_req, mem_we, if_done, d_done, err and busy SHALL become 0; mem_addr, mem_wdata and rdata SHALL become 0; the counter SHALL become 0.
REQ-031 Reset in the middle of a transaction SHALL drop mem_req at the next edge and SHALL NOT generate a done pulse.

Structure
REQ-032 Shared package rv_pkg SHALL hold the arb_state_t enum (IDLE, DACC, IACC, RESP), the arb_src_t enum (SRC_I, SRC_D) and the TIMEOUT default constant.
REQ-033 The timeout counter SHALL be a sub-module rv_tmo_cnt with inputs clr and en, outputs expired, and parameter TIMEOUT.

Verification
REQ-034 Fetch, zero wait: if_req=1 with if_addr=0x100 and mem_ack=1 in the first mem_req cycle with mem_rdata=0x00500093 -> if_done high 2 cycles after the request is sampled, rdata=0x00500093, err=0.
REQ-035 Simultaneous requests: d_req=1 (write, 0x2000, 0xDEADBEEF) and if_req=1 -> the write is issued first with mem_we=1; the fetch is issued after d_done and IDLE.
REQ-036 Wait states: mem_ack delayed 5 cycles -> mem_req, mem_addr and mem_wdata stay stable for 6 cycles; d_done follows the ack by 1 cycle.
REQ-037 Timeout: TIMEOUT=16 with mem_ack never asserted -> mem_req high for exactly 16 cycles, then if_done=1, err=1, rdata=0, FSM back in IDLE.
REQ-038 Reset mid-operation: rst asserted in the 3rd DACC cycle -> mem_req=0 and busy=0 next cycle, no d_done, and a new if_req is served normally.
REQ-039 Ack at the boundary: mem_ack arrives in the cycle the count reaches TIMEOUT -> done with err=0 and valid rdata; a stray mem_ack in IDLE causes no effect.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package rv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

  localparam int TIMEOUT_DEF = 16;

  function automatic logic is_access(arb_state_t s);
    return (s == DACC) || (s == IACC);
  endfunction

endpackage

// File: rtl/rv_mem_arb_if.sv
// Unified memory request/response bus between the arbiter and memory.
interface rv_mem_arb_if #(
  parameter int DPWIDTH = 32
);
  logic               mem_req;
  logic               mem_we;
  logic [DPWIDTH-1:0] mem_addr;
  logic [DPWIDTH-1:0] mem_wdata;
  logic               mem_ack;
  logic [DPWIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/rv_tmo_cnt.sv
// Access timeout: down-counter loaded on clr, expired at terminal count while enabled.
module rv_tmo_cnt
  import rv_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Loaded with TIMEOUT-1 so the last allowed access cycle sees zero; holds at zero.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= LOAD;
    else if (en && (cnt != '0))
      cnt <= cnt - CW'(1);
  end

  assign expired = en && (cnt == '0);
endmodule

// File: rtl/rv_mem_arb.sv
// Arbitrates instruction fetch and data access onto one memory port; data wins ties.
// state | meaning
// IDLE  | waiting for a request, data first
// DACC  | data access on the memory bus
// IACC  | fetch access on the memory bus
// RESP  | one-cycle done pulse to the latched source
module rv_mem_arb
  import rv_pkg::*;
#(
  parameter int DPWIDTH = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [DPWIDTH-1:0] if_addr,
  output logic               if_done,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [DPWIDTH-1:0] d_addr,
  input  logic [DPWIDTH-1:0] d_wdata,
  output logic               d_done,
  output logic [DPWIDTH-1:0] rdata,
  output logic               err,
  output logic               busy,
  rv_mem_arb_if.master       mem
);
  arb_state_t state, state_nxt;
  arb_src_t   src, src_nxt;
  logic       tmo_expired;
  logic       resp_entry;

  logic               mem_req_nxt, mem_we_nxt;
  logic [DPWIDTH-1:0] mem_addr_nxt, mem_wdata_nxt, rdata_nxt;
  logic               if_done_nxt, d_done_nxt, err_nxt, busy_nxt;

  rv_tmo_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (!is_access(state)),
    .en      (is_access(state)),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      src           <= SRC_I;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      rdata         <= '0;
      if_done       <= 1'b0;
      d_done        <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      src           <= src_nxt;
      mem.mem_req   <= mem_req_nxt;
      mem.mem_we    <= mem_we_nxt;
      mem.mem_addr  <= mem_addr_nxt;
      mem.mem_wdata <= mem_wdata_nxt;
      rdata         <= rdata_nxt;
      if_done       <= if_done_nxt;
      d_done        <= d_done_nxt;
      err           <= err_nxt;
      busy          <= busy_nxt;
    end
  end

  // An ack in the timeout cycle still completes the access cleanly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_req)
          state_nxt = DACC;
        else if (if_req)
          state_nxt = IACC;
      end
      DACC, IACC: begin
        if (mem.mem_ack || tmo_expired)
          state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    resp_entry    = is_access(state) && (state_nxt == RESP);
    src_nxt       = src;
    mem_req_nxt   = is_access(state_nxt);
    mem_we_nxt    = mem.mem_we;
    mem_addr_nxt  = mem.mem_addr;
    mem_wdata_nxt = mem.mem_wdata;
    if ((state == IDLE) && (state_nxt == DACC)) begin
      src_nxt       = SRC_D;
      mem_we_nxt    = d_we;
      mem_addr_nxt  = d_addr;
      mem_wdata_nxt = d_wdata;
    end else if ((state == IDLE) && (state_nxt == IACC)) begin
      src_nxt       = SRC_I;
      mem_we_nxt    = 1'b0;
      mem_addr_nxt  = if_addr;
      mem_wdata_nxt = '0;
    end else if (!is_access(state_nxt)) begin
      mem_we_nxt    = 1'b0;
    end
    rdata_nxt = rdata;
    if (resp_entry)
      rdata_nxt = mem.mem_ack ? mem.mem_rdata : '0;
    if_done_nxt = resp_entry && (src == SRC_I);
    d_done_nxt  = resp_entry && (src == SRC_D);
    err_nxt     = resp_entry && !mem.mem_ack;
    busy_nxt    = (state_nxt != IDLE);
  end
endmodule

// File: tb/tb_rv_mem_arb.sv
// Scoreboard bench for rv_mem_arb: directed transactions, memory responder, decoupled monitor.
module tb_rv_mem_arb;
  localparam int DW  = 32;
  localparam int TMO = 16;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          cycles;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req, d_req, d_we;
  logic [DW-1:0] if_addr, d_addr, d_wdata;
  logic          if_done, d_done, err, busy;
  logic [DW-1:0] rdata;

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb[$];
  int          ack_wait = 0;
  logic [31:0] ack_data = '0;
  logic        stray    = 1'b0;
  int          wcnt     = 0;

  always #5 clk = ~clk;

  rv_mem_arb_if #(.DPWIDTH(DW)) mbus ();

  rv_mem_arb #(.DPWIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_done (if_done),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_done  (d_done),
    .rdata   (rdata),
    .err     (err),
    .busy    (busy),
    .mem     (mbus)
  );

  // Memory model: acks in access cycle ack_wait+1 (never when ack_wait < 0).
  always @(posedge clk) begin
    #1;
    mbus.mem_rdata = ack_data;
    if (rst || !mbus.mem_req) begin
      mbus.mem_ack = stray;
      wcnt = 0;
    end else begin
      mbus.mem_ack = (ack_wait >= 0) && (wcnt == ack_wait);
      wcnt++;
    end
  end

  function automatic exp_t mk(bit is_d, bit we, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, bit e, int cyc);
    exp_t x;
    x.is_d = is_d; x.we = we; x.addr = a; x.wdata = wd;
    x.rdata = rd; x.err = e; x.cycles = cyc;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    int   reqc;
    exp_t e;
    reqc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        reqc = 0;
      end else begin
        if (mbus.mem_req) begin
          reqc++;
          if (sb.size() > 0) begin
            chk("mem_addr", mbus.mem_addr, sb[0].addr);
            chk("mem_we", 32'(mbus.mem_we), 32'(sb[0].we));
            chk("mem_wdata", mbus.mem_wdata, sb[0].wdata);
          end
        end
        if (err && !(if_done || d_done)) begin
          checks++;
          failures++;
          $display("FAIL err_without_done actual=1 expected=0 t=%0t", $time);
        end
        if (if_done || d_done) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done if_done=%b d_done=%b expected none t=%0t",
                     if_done, d_done, $time);
          end else begin
            e = sb.pop_front();
            chk("d_done", 32'(d_done), 32'(e.is_d));
            chk("if_done", 32'(if_done), 32'(!e.is_d));
            chk("err", 32'(err), 32'(e.err));
            chk("req_cycles", reqc, e.cycles);
            if (!e.we) chk("rdata", rdata, e.rdata);
          end
          reqc = 0;
        end
      end
    end
  endtask

  task automatic do_d(input logic we, input logic [31:0] a, input logic [31:0] wd, output int lat);
    bit got;
    got = 0;
    lat = 0;
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      lat = i + 1;
      if (d_done) got = 1;
    end
    d_req = 1'b0;
    chk("d_done_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_i(input logic [31:0] a, input bit hold, output int lat);
    bit got;
    got = 0;
    lat = 0;
    if_addr = a; if_req = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      lat = i + 1;
      if (!hold) if_req = 1'b0;
      if (if_done) got = 1;
    end
    if_req = 1'b0;
    chk("if_done_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat_d, lat_i;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mbus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(mbus.mem_we), 32'd0);
    chk("rst_mem_addr", mbus.mem_addr, 32'd0);
    chk("rst_mem_wdata", mbus.mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'({if_done, d_done}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // zero-wait fetch
    ack_wait = 0; ack_data = 32'h0050_0093;
    sb.push_back(mk(0, 0, 32'h100, 32'h0, 32'h0050_0093, 0, 1));
    do_i(32'h100, 1, lat_i);
    chk("fetch_latency", lat_i, 2);

    // simultaneous: write first, then fetch
    ack_wait = 0; ack_data = 32'h1234_5678;
    sb.push_back(mk(1, 1, 32'h2000, 32'hDEAD_BEEF, 32'h0, 0, 1));
    sb.push_back(mk(0, 0, 32'h3000, 32'h0, 32'h1234_5678, 0, 1));
    fork
      do_d(1'b1, 32'h2000, 32'hDEAD_BEEF, lat_d);
      do_i(32'h3000, 1, lat_i);
    join
    chk("both_served_order", 32'(lat_i > lat_d), 32'd1);

    // wait states on a write, then a read with two waits
    ack_wait = 5; ack_data = 32'h0;
    sb.push_back(mk(1, 1, 32'h44, 32'hA5A5_0F0F, 32'h0, 0, 6));
    do_d(1'b1, 32'h44, 32'hA5A5_0F0F, lat_d);
    ack_wait = 2; ack_data = 32'h0BAD_F00D;
    sb.push_back(mk(1, 0, 32'h48, 32'h55AA, 32'h0BAD_F00D, 0, 3));
    do_d(1'b0, 32'h48, 32'h55AA, lat_d);

    // timeout
    ack_wait = -1; ack_data = 32'hFFFF_FFFF;
    sb.push_back(mk(0, 0, 32'h200, 32'h0, 32'h0, 1, TMO));
    do_i(32'h200, 1, lat_i);
    chk("tmo_busy_after", 32'(busy), 32'd0);
    chk("tmo_mem_req_after", 32'(mbus.mem_req), 32'd0);

    // ack in the last allowed cycle wins
    ack_wait = TMO - 1; ack_data = 32'h600D_D00D;
    sb.push_back(mk(0, 0, 32'h204, 32'h0, 32'h600D_D00D, 0, TMO));
    do_i(32'h204, 1, lat_i);

    // stray ack in IDLE
    stray = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stray_busy", 32'(busy), 32'd0);
      chk("stray_mem_req", 32'(mbus.mem_req), 32'd0);
    end
    stray = 1'b0;
    @(posedge clk); #1;

    // request dropped mid-access still completes
    ack_wait = 3; ack_data = 32'h7777_0001;
    sb.push_back(mk(0, 0, 32'h180, 32'h0, 32'h7777_0001, 0, 4));
    do_i(32'h180, 0, lat_i);

    // reset in the third DACC cycle
    ack_wait = -1;
    d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h77; d_req = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_mem_req_before_rst", 32'(mbus.mem_req), 32'd1);
    rst = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_mem_req", 32'(mbus.mem_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    ack_wait = 1; ack_data = 32'h0000_0011;
    sb.push_back(mk(0, 0, 32'h108, 32'h0, 32'h0000_0011, 0, 2));
    do_i(32'h108, 1, lat_i);
    chk("post_rst_latency", lat_i, 3);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
